// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// A Moore-style FSM steps the shared-memory, shared-ALU datapath through
// fetch, decode and the per-class execute/memory/writeback steps. Outputs
// follow the current state. Only ir_write/pc_en/instr_done react to
// mem_ready, and only pc_en reacts to zero. Reset forces every output low in
// the same cycle it is seen, so a write in flight is cut off at once.
module mips_multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(4'd0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(4'd1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(4'd2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(4'd3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4'd4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(4'd5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(4'd6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(4'd7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(4'd8);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(4'd9);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(4'd10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(4'd11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               rdy_s;
  logic               funct_legal_s;
  logic [2:0]         funct_alu_s;

  // With the wait handshake disabled, memory is treated as always ready.
  assign rdy_s = mem_ready | ~MEM_WAIT_EN;

  // The debug view reads zero while reset is held, like every other output.
  assign dbg_state = reset ? '0 : state_q;

  // R-type funct decode: ALU operation plus a legality flag used in DECODE.
  always_comb begin
    funct_legal_s = 1'b1;
    funct_alu_s   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu_s = ALU_ADD;
      FN_SUB:  funct_alu_s = ALU_SUB;
      FN_AND:  funct_alu_s = ALU_AND;
      FN_OR:   funct_alu_s = ALU_OR;
      FN_SLT:  funct_alu_s = ALU_SLT;
      default: begin
        funct_legal_s = 1'b0;
        funct_alu_s   = ALU_ADD;
      end
    endcase
  end

  // Per-state datapath controls and next-state selection.
  always_comb begin
    state_d       = S_FETCH;
    pc_en         = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_control   = 3'b000;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          alu_control = ALU_ADD;
          alu_src_b   = 2'b01;
          ir_write    = rdy_s;
          pc_en       = rdy_s;
          state_d     = rdy_s ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          // Branch target is precomputed into ALUOut while decoding.
          alu_control = ALU_ADD;
          alu_src_b   = 2'b11;
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            OP_RTYPE: begin
              if (funct_legal_s) begin
                state_d = S_EXEC;
              end else begin
                illegal_instr = 1'b1;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
              end
            end
            default: begin
              illegal_instr = 1'b1;
              instr_done    = 1'b1;
              state_d       = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_control = ALU_ADD;
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          alu_control = ALU_ADD;
          iord        = 1'b1;
          state_d     = rdy_s ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          alu_control = ALU_ADD;
          mem_to_reg  = 1'b1;
          reg_write   = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_MEMWR: begin
          // The write strobe stays up until memory accepts it.
          alu_control = ALU_ADD;
          iord        = 1'b1;
          mem_write   = 1'b1;
          instr_done  = rdy_s;
          state_d     = rdy_s ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_control = funct_alu_s;
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b00;
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          alu_control = ALU_ADD;
          reg_dst     = 1'b1;
          reg_write   = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_BRANCH: begin
          alu_control = ALU_SUB;
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b00;
          pc_src      = 2'b01;
          pc_en       = zero;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_ADDIEX: begin
          alu_control = ALU_ADD;
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          state_d     = S_ADDIWB;
        end
        S_ADDIWB: begin
          alu_control = ALU_ADD;
          reg_write   = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          alu_control = ALU_ADD;
          pc_src      = 2'b10;
          pc_en       = 1'b1;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        default: begin
          // Unused codes recover to FETCH with everything held low.
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
